wishbone_sram_banked: RTL and testbench
=======================================

Name: wishbone_sram_banked

Overview:
- Wishbone slave that maps a contiguous window onto NUM_BANKS single-port OpenRAM macros (RW port 0 each).
- Successor to the single-macro wrapper. Adds:
  - parametrised bank count and depth
  - word (not byte) addressing
  - a registered single-outstanding FSM
  - configurable macro read latency
  - out-of-range bank handling
- Sits between the user-project Wishbone bus and the SRAM macro array in the user area.

Parameters:
- BASE_ADDR, 32'h30c0_0000, window base. Must be aligned to the full window size.
- ADDR_WIDTH, 8, word-address bits per macro (depth = 2**ADDR_WIDTH words of 32 bits).
- NUM_BANKS, 2, number of macros (1..8). BANK_BITS = max(1, clog2(NUM_BANKS)).
- READ_LATENCY, 1, cycles from the macro's capturing edge to valid read data (1..4).

Ports:
- wb_clk_i  in  1  bus and macro clock
- wb_rst_ni  in  1  synchronous active-low reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  byte address
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- ram_clk0  out  1  macro clock; equals wb_clk_i
- ram_csb0  out  NUM_BANKS  per-bank active-low chip select
- ram_web0  out  1  active-low write enable, shared by all banks
- ram_wmask0  out  4  byte write mask, shared
- ram_addr0  out  ADDR_WIDTH  word address, shared
- ram_dout0  out  32  write data to the macros, shared
- ram_din0  in  NUM_BANKS*32  read data; bank k occupies bits [32k+31:32k]

Behaviour:
- Decode:
  - hit = stb & cyc & ((wbs_adr_i & HI_MASK) == BASE_ADDR), where HI_MASK clears the low ADDR_WIDTH+2+BANK_BITS bits.
  - Word address = adr[ADDR_WIDTH+1:2].
  - Bank = adr[ADDR_WIDTH+1+BANK_BITS:ADDR_WIDTH+2].
  - adr[1:0] is ignored.
- All state updates on posedge wb_clk_i. All outputs except ram_clk0 are registered.
- Reset (wb_rst_ni=0 at posedge), from any state including mid-operation:
  - state=IDLE, ram_csb0 all 1, ram_web0=1, ram_wmask0=0, ram_addr0=0, ram_dout0=0
  - wbs_ack_o=0, wbs_dat_o=0, latency counter=0
- FSM states: IDLE, ACCESS, WAIT, ACK.
  - IDLE: on hit, latch address, bank, we, sel and data. Valid bank goes to ACCESS. Bank >= NUM_BANKS goes to ACK with data 0 and no chip select.
  - ACCESS (exactly 1 cycle):
    - Selected ram_csb0 bit = 0; ram_web0=~we; ram_wmask0=sel.
    - ram_wmask0 is driven for writes only; it is 0 on reads.
    - Write: go to ACK. Read: load counter=READ_LATENCY, go to WAIT.
  - WAIT: all csb=1; counter decrements. At counter==1, capture ram_din0 of the latched bank into wbs_dat_o, then go to ACK.
  - ACK (1 cycle): wbs_ack_o = ack_r & stb & cyc, then go to IDLE. No new request is accepted in ACK, so back-to-back requests start the cycle after ACK.
- Latency, measured from the first cycle stb&cyc&hit is sampled to ack high:
  - write: 2 cycles
  - read: 2+READ_LATENCY cycles
  - out-of-range: 1 cycle
- Abort: if stb or cyc drops mid-transaction, the RAM access still completes, ack is suppressed, and the FSM returns to IDLE. A write that has already issued is not undone.
- wbs_dat_o holds its last value between reads. It is written with 0 on writes and on out-of-range accesses.
- Non-hit addresses: no response, FSM stays in IDLE.

Optional Feature:
- Macro: WB_SRAM_BANKED_ERR_EN.
- Defined:
  - Adds output port wbs_err_o (1 bit, reset 0).
  - An out-of-range bank asserts wbs_err_o instead of wbs_ack_o, for 1 cycle, with the same gating by stb & cyc.
- Undefined:
  - Port is absent.
  - An out-of-range bank acks with wbs_dat_o=0, and writes are dropped.

Test Plan:
- Reset, defaults: hold wb_rst_ni=0 for 3 cycles -> all ram_csb0=1, ack=0, dat_o=0; release, then idle 5 cycles -> no csb activity.
- Write then read, bank 1:
  - Write 0xDEADBEEF to 0x30c0_0404, sel=4'hF -> ram_csb0=2'b01, addr0=0x01, web0=0, wmask0=4'hF; ack 2 cycles after stb.
  - Read the same address with model latency 1 -> dat_o=0xDEADBEEF; ack 3 cycles after stb.
- Byte mask, bank 0: write 0x11223344 to 0x30c0_0008 with sel=4'b0101 -> wmask0=4'b0101, ram_dout0=0x11223344.
- Abort, READ_LATENCY=3: start a read, drop stb in WAIT -> ack never asserts; the next read is accepted and acks 5 cycles after its stb.
- Reset mid-operation and out-of-range bank:
  - Assert wb_rst_ni=0 during ACCESS -> next cycle csb all 1, state IDLE, no ack.
  - With NUM_BANKS=3, access bank 3 -> no csb low; ack (or err with ERR_EN) 1 cycle later, dat_o=0.
- Outside window: access 0x30d0_0000 -> no ack, no csb activity for 10 cycles.

Source files
------------

// File: rtl/wishbone_sram_banked.sv
// Wishbone slave mapping a word-addressed window onto NUM_BANKS single-port SRAM macros.
// Define WB_SRAM_BANKED_ERR_EN to add wbs_err_o, raised instead of ack for an out-of-range bank.
module wishbone_sram_banked #(
    parameter logic [31:0] BASE_ADDR    = 32'h30c0_0000,
    parameter int          ADDR_WIDTH   = 8,
    parameter int          NUM_BANKS    = 2,
    parameter int          READ_LATENCY = 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_dat_i,
    input  logic [31:0]               wbs_adr_i,
    output logic                      wbs_ack_o,
`ifdef WB_SRAM_BANKED_ERR_EN
    output logic                      wbs_err_o,
`endif
    output logic [31:0]               wbs_dat_o,
    output logic                      ram_clk0,
    output logic [NUM_BANKS-1:0]      ram_csb0,
    output logic                      ram_web0,
    output logic [3:0]                ram_wmask0,
    output logic [ADDR_WIDTH-1:0]     ram_addr0,
    output logic [31:0]               ram_dout0,
    input  logic [NUM_BANKS*32-1:0]   ram_din0
);

    localparam int          BANK_BITS = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1;
    localparam int          LOW_BITS  = ADDR_WIDTH + 2 + BANK_BITS;
    localparam logic [31:0] HI_MASK   = ~((32'd1 << LOW_BITS) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    state_t                 state_r;
    logic [BANK_BITS-1:0]   bank_r;
    logic                   we_r;
    logic                   abort_r;
    logic                   ack_r;
    logic [2:0]             lat_r;
`ifdef WB_SRAM_BANKED_ERR_EN
    logic                   err_r;
`endif

    logic                   req_s;
    logic                   hit_s;
    logic [BANK_BITS-1:0]   bank_s;
    logic                   bank_ok_s;
    logic [31:0]            bank_rdata_s;

    // Active-low one-hot chip select for a single bank
    function automatic logic [NUM_BANKS-1:0] bank_csb(input logic [BANK_BITS-1:0] bank);
        logic [NUM_BANKS-1:0] csb_s;
        for (int k = 0; k < NUM_BANKS; k++) begin
            csb_s[k] = (bank != BANK_BITS'(k));
        end
        return csb_s;
    endfunction

    assign ram_clk0  = wb_clk_i;
    assign req_s     = wbs_stb_i & wbs_cyc_i;
    assign hit_s     = req_s & ((wbs_adr_i & HI_MASK) == BASE_ADDR);
    assign bank_s    = wbs_adr_i[ADDR_WIDTH+2 +: BANK_BITS];
    assign bank_ok_s = ({{(32-BANK_BITS){1'b0}}, bank_s} < 32'(NUM_BANKS));
    assign wbs_ack_o = ack_r & req_s;
`ifdef WB_SRAM_BANKED_ERR_EN
    assign wbs_err_o = err_r & req_s;
`endif

    // Read-data mux for the bank latched at request time
    always_comb begin
        bank_rdata_s = 32'd0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (bank_r == BANK_BITS'(k)) begin
                bank_rdata_s = ram_din0[32*k +: 32];
            end else begin
                bank_rdata_s = bank_rdata_s;
            end
        end
    end

    // Single-outstanding access FSM with registered bus and macro outputs
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_r    <= ST_IDLE;
            bank_r     <= '0;
            we_r       <= 1'b0;
            abort_r    <= 1'b0;
            ack_r      <= 1'b0;
            lat_r      <= 3'd0;
            wbs_dat_o  <= 32'd0;
            ram_csb0   <= '1;
            ram_web0   <= 1'b1;
            ram_wmask0 <= 4'd0;
            ram_addr0  <= '0;
            ram_dout0  <= 32'd0;
`ifdef WB_SRAM_BANKED_ERR_EN
            err_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r   <= 1'b0;
                    abort_r <= 1'b0;
                    if (hit_s) begin
                        bank_r <= bank_s;
                        we_r   <= wbs_we_i;
                        if (bank_ok_s) begin
                            state_r    <= ST_ACCESS;
                            ram_csb0   <= bank_csb(bank_s);
                            ram_web0   <= ~wbs_we_i;
                            ram_wmask0 <= wbs_we_i ? wbs_sel_i : 4'd0;
                            ram_addr0  <= wbs_adr_i[ADDR_WIDTH+1:2];
                            ram_dout0  <= wbs_dat_i;
                            if (wbs_we_i) begin
                                wbs_dat_o <= 32'd0;
                            end
                        end else begin
                            // Nothing reaches the macros; respond next cycle with zero data
                            state_r   <= ST_ACK;
                            wbs_dat_o <= 32'd0;
`ifdef WB_SRAM_BANKED_ERR_EN
                            err_r     <= 1'b1;
`else
                            ack_r     <= 1'b1;
`endif
                        end
                    end
                end
                ST_ACCESS: begin
                    ram_csb0   <= '1;
                    ram_web0   <= 1'b1;
                    ram_wmask0 <= 4'd0;
                    if (we_r) begin
                        if (req_s) begin
                            state_r <= ST_ACK;
                            ack_r   <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                        lat_r   <= 3'(READ_LATENCY);
                        abort_r <= ~req_s;
                    end
                end
                ST_WAIT: begin
                    if (lat_r == 3'd1) begin
                        wbs_dat_o <= bank_rdata_s;
                        lat_r     <= 3'd0;
                        // A master that let go at any point gets no ack
                        if (abort_r || !req_s) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_ACK;
                            ack_r   <= 1'b1;
                        end
                    end else begin
                        lat_r   <= lat_r - 3'd1;
                        abort_r <= abort_r | ~req_s;
                    end
                end
                ST_ACK: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
`ifdef WB_SRAM_BANKED_ERR_EN
                    err_r   <= 1'b0;
`endif
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ack_r      <= 1'b0;
                    ram_csb0   <= '1;
                    ram_web0   <= 1'b1;
                    ram_wmask0 <= 4'd0;
`ifdef WB_SRAM_BANKED_ERR_EN
                    err_r      <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_sram_banked.sv
// Scoreboard bench for wishbone_sram_banked with 3 banks and 3-cycle macro read latency.
// Builds with or without WB_SRAM_BANKED_ERR_EN.
module tb_wishbone_sram_banked;

    localparam int NB = 3;
    localparam int RL = 3;
    localparam int AW = 8;
`ifdef WB_SRAM_BANKED_ERR_EN
    localparam logic OOB_ERR = 1'b1;
`else
    localparam logic OOB_ERR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]      sel = 4'd0;
    logic [31:0]     dat_i = 32'd0, adr = 32'd0;
    logic            wbs_ack_o;
    logic            err_s;
    logic [31:0]     wbs_dat_o;
    logic            ram_clk0, ram_web0;
    logic [NB-1:0]   ram_csb0;
    logic [3:0]      ram_wmask0;
    logic [AW-1:0]   ram_addr0;
    logic [31:0]     ram_dout0;
    logic [NB*32-1:0] ram_din0;

    always #5 clk = ~clk;

    wishbone_sram_banked #(
        .BASE_ADDR(32'h30c0_0000), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .READ_LATENCY(RL)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
        .wbs_ack_o(wbs_ack_o),
`ifdef WB_SRAM_BANKED_ERR_EN
        .wbs_err_o(err_s),
`endif
        .wbs_dat_o(wbs_dat_o), .ram_clk0(ram_clk0), .ram_csb0(ram_csb0),
        .ram_web0(ram_web0), .ram_wmask0(ram_wmask0), .ram_addr0(ram_addr0),
        .ram_dout0(ram_dout0), .ram_din0(ram_din0)
    );

`ifndef WB_SRAM_BANKED_ERR_EN
    assign err_s = 1'b0;
`endif

    // Macro model: byte-masked write, RL-stage read pipeline per bank
    logic [31:0] mem  [NB][2**AW];
    logic [31:0] pipe [NB][RL];
    logic        mem_clr = 1'b1;

    always @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (mem_clr) begin
                for (int a = 0; a < 2**AW; a++) mem[k][a] <= 32'd0;
            end else if (!ram_csb0[k]) begin
                if (!ram_web0) begin
                    for (int b = 0; b < 4; b++)
                        if (ram_wmask0[b]) mem[k][ram_addr0][8*b +: 8] <= ram_dout0[8*b +: 8];
                end else begin
                    pipe[k][0] <= mem[k][ram_addr0];
                end
            end
            for (int s = 1; s < RL; s++) pipe[k][s] <= pipe[k][s-1];
        end
    end

    for (genvar k = 0; k < NB; k++) begin : g_din
        assign ram_din0[32*k +: 32] = pipe[k][RL-1];
    end

    typedef struct {
        logic [31:0] dat;
        int          lat;
        logic        err;
        int          t0;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0, n_pass = 0;
    int   cnt = 0, ack_cnt = 0, csb_act = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cnt++;
    end

    // csb activity counter, used as deltas over quiet windows
    initial forever begin
        @(negedge clk);
        if (ram_csb0 != {NB{1'b1}}) csb_act++;
    end

    // Response monitor: pops one expectation per ack/err
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (wbs_ack_o || err_s) begin
            ack_cnt++;
            chk("resp_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("resp_dat", wbs_dat_o, e.dat);
                chk("resp_latency", 32'(cnt - e.t0), 32'(e.lat));
`ifdef WB_SRAM_BANKED_ERR_EN
                chk("resp_err", 32'(err_s), 32'(e.err));
`endif
            end
        end
    end

    task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] exp_dat, input int exp_lat,
                        input logic exp_err, input logic chk_ram, input logic [NB-1:0] e_csb,
                        input logic e_web, input logic [3:0] e_wmask, input logic [AW-1:0] e_addr,
                        input logic [31:0] e_dout);
        int  c;
        bit  got;
        exp_t e;
        @(negedge clk); #1;
        adr = a; we = w; sel = s; dat_i = d; stb = 1'b1; cyc = 1'b1;
        c = cnt;
        e.dat = exp_dat; e.lat = exp_lat; e.err = exp_err; e.t0 = c;
        sb_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (chk_ram && cnt == c + 1) begin
                chk("access_csb", 32'(ram_csb0), 32'(e_csb));
                chk("access_web", 32'(ram_web0), 32'(e_web));
                chk("access_wmask", 32'(ram_wmask0), 32'(e_wmask));
                chk("access_addr", 32'(ram_addr0), 32'(e_addr));
                chk("access_dout", ram_dout0, e_dout);
            end
            if (wbs_ack_o || err_s) got = 1'b1;
        end
        #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        chk("resp_arrived", 32'(got), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, c0, c;
        // Reset defaults
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_csb", 32'(ram_csb0), 32'h7);
        chk("rst_ack", 32'(wbs_ack_o), 32'd0);
        chk("rst_dat", wbs_dat_o, 32'd0);
        chk("rst_web", 32'(ram_web0), 32'd1);
        chk("rst_wmask", 32'(ram_wmask0), 32'd0);
        chk("rst_addr", 32'(ram_addr0), 32'd0);
        chk("rst_dout", ram_dout0, 32'd0);
        #1; rst_n = 1'b1; mem_clr = 1'b0;
        c0 = csb_act;
        repeat (5) @(negedge clk);
        chk("idle_csb_quiet", 32'(csb_act - c0), 32'd0);

        // Write then read, bank 1
        xfer(32'h30c0_0404, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0, 2, 1'b0,
             1'b1, 3'b101, 1'b0, 4'hF, 8'h01, 32'hDEAD_BEEF);
        xfer(32'h30c0_0404, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 2 + RL, 1'b0,
             1'b1, 3'b101, 1'b1, 4'h0, 8'h01, 32'h0);

        // Byte mask, bank 0, then read back the merged word
        xfer(32'h30c0_0008, 1'b1, 4'b0101, 32'h1122_3344, 32'h0, 2, 1'b0,
             1'b1, 3'b110, 1'b0, 4'b0101, 8'h02, 32'h1122_3344);
        xfer(32'h30c0_000b, 1'b0, 4'hF, 32'h0, 32'h0022_0044, 2 + RL, 1'b0,
             1'b1, 3'b110, 1'b1, 4'h0, 8'h02, 32'h0);

        // Abort: drop stb while the read is waiting on the macro
        @(negedge clk); #1;
        adr = 32'h30c0_0404; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        c = cnt; a0 = ack_cnt;
        while (cnt < c + 2) @(negedge clk);
        #1; stb = 1'b0; cyc = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_ack", 32'(ack_cnt - a0), 32'd0);
        xfer(32'h30c0_0404, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 2 + RL, 1'b0,
             1'b0, 3'b111, 1'b1, 4'h0, 8'h0, 32'h0);

        // Reset during ACCESS
        @(negedge clk); #1;
        adr = 32'h30c0_0404; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        a0 = ack_cnt;
        @(negedge clk);
        chk("midrst_in_access", 32'(ram_csb0), 32'b101);
        #1; rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_csb", 32'(ram_csb0), 32'h7);
        chk("midrst_ack", 32'(wbs_ack_o), 32'd0);
        chk("midrst_dat", wbs_dat_o, 32'd0);
        #1; stb = 1'b0; cyc = 1'b0;
        @(negedge clk); #1; rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_no_ack", 32'(ack_cnt - a0), 32'd0);
        xfer(32'h30c0_0404, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 2 + RL, 1'b0,
             1'b0, 3'b111, 1'b1, 4'h0, 8'h0, 32'h0);

        // Out-of-range bank 3: no chip select, one-cycle response with zero data
        c0 = csb_act;
        xfer(32'h30c0_0c00, 1'b0, 4'hF, 32'h0, 32'h0, 1, OOB_ERR,
             1'b0, 3'b111, 1'b1, 4'h0, 8'h0, 32'h0);
        xfer(32'h30c0_0c04, 1'b1, 4'hF, 32'h5555_AAAA, 32'h0, 1, OOB_ERR,
             1'b0, 3'b111, 1'b1, 4'h0, 8'h0, 32'h0);
        chk("oob_csb_quiet", 32'(csb_act - c0), 32'd0);

        // Outside the window
        @(negedge clk); #1;
        adr = 32'h30d0_0000; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        c0 = csb_act; a0 = ack_cnt;
        repeat (10) @(negedge clk);
        chk("miss_csb_quiet", 32'(csb_act - c0), 32'd0);
        chk("miss_no_ack", 32'(ack_cnt - a0), 32'd0);
        #1; stb = 1'b0; cyc = 1'b0;
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
